// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - sweep sequencer driving an 8-bit up/down counter
// Loads the counter, watches its count, and reverses or reloads it at the sweep end points.
module counter_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic [1:0]       cmd_mode,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             abort,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_load,
  output logic             cnt_u_d,
  output logic [WIDTH-1:0] cnt_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic [1:0]       mode_q, mode_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic             dir_q, dir_d;
  logic             leg_q, leg_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] target;
  logic             reach;
  logic             is_tri;
  logic             is_down;

  assign target  = leg_q ? start_q : end_q;
  assign reach   = (count == target);
  assign is_tri  = (mode_q == 2'b10);
  assign is_down = (mode_q == 2'b01);
  assign done    = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      start_q <= '0;
      end_q   <= '0;
      mode_q  <= '0;
      reps_q  <= '0;
      dir_q   <= 1'b0;
      leg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      mode_q  <= mode_d;
      reps_q  <= reps_d;
      dir_q   <= dir_d;
      leg_q   <= leg_d;
      done_q  <= done_d;
    end
  end

  // The counter has no enable, so every non-counting cycle reloads its own value.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    end_d     = end_q;
    mode_d    = mode_q;
    reps_d    = reps_q;
    dir_d     = dir_q;
    leg_d     = leg_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    cnt_load  = 1'b1;
    cnt_data  = count;
    cnt_u_d   = 1'b1;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          start_d = cmd_start;
          end_d   = cmd_end;
          mode_d  = cmd_mode;
          reps_d  = cmd_reps;
          leg_d   = 1'b0;
          dir_d   = (cmd_mode != 2'b01);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_data = start_q;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_load = 1'b0;
          cnt_u_d  = dir_q;
          if (reach) begin
            // Turn-around must steer this same cycle so the far end is not overshot.
            if (is_tri && !leg_q && (start_q != end_q)) begin
              dir_d   = ~dir_q;
              cnt_u_d = ~dir_q;
              leg_d   = 1'b1;
            end else if (reps_q != '0) begin
              cnt_load = 1'b1;
              cnt_data = start_q;
              reps_d   = reps_q - REP_W'(1);
              leg_d    = 1'b0;
              dir_d    = ~is_down;
            end else begin
              cnt_load = 1'b1;
              state_d  = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - directed vector bench for counter_seq_ctrl
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_start;
  logic [7:0] cmd_end;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_reps;
  logic       abort;
  logic [7:0] count = 8'd0;
  logic       cnt_load;
  logic       cnt_u_d;
  logic [7:0] cnt_data;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  counter_seq_ctrl #(.WIDTH(8), .REP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_end   (cmd_end),
    .cmd_mode  (cmd_mode),
    .cmd_reps  (cmd_reps),
    .abort     (abort),
    .count     (count),
    .cnt_load  (cnt_load),
    .cnt_u_d   (cnt_u_d),
    .cnt_data  (cnt_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit up/down counter with load and no enable.
  always @(posedge clk) begin
    if (cnt_load)     count <= cnt_data;
    else if (cnt_u_d) count <= count + 8'd1;
    else              count <= count - 8'd1;
  end

  typedef struct {
    logic [7:0] s;
    logic [7:0] e;
    logic [1:0] m;
    logic [3:0] r;
    int         cyc;
    logic [7:0] fin;
    int         off;
    int         len;
  } vec_t;

  vec_t vecs[8];
  int   pool[];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v, input int k);
    logic [7:0] got[$];
    int         cyc;
    bit         seen;
    @(negedge clk);
    chk($sformatf("v%0d_ready", k), cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_start = v.s;
    cmd_end   = v.e;
    cmd_mode  = v.m;
    cmd_reps  = v.r;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk($sformatf("v%0d_load_busy", k), busy, 1);
    chk($sformatf("v%0d_load_data", k), {cnt_load, cnt_data}, {1'b1, v.s});
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      got.push_back(count);
    end
    chk($sformatf("v%0d_done_seen", k), seen, 1);
    chk($sformatf("v%0d_cycles", k), cyc, v.cyc);
    chk($sformatf("v%0d_seq_len", k), got.size(), v.len);
    for (int i = 0; i < v.len && i < got.size(); i++)
      chk($sformatf("v%0d_seq%0d", k, i), got[i], pool[v.off + i]);
    chk($sformatf("v%0d_done_ready", k), cmd_ready, 0);
    chk($sformatf("v%0d_done_count", k), count, v.fin);
    @(negedge clk);
    chk($sformatf("v%0d_post_done", k), done, 0);
    chk($sformatf("v%0d_post_ready", k), {cmd_ready, busy}, 2'b10);
    chk($sformatf("v%0d_post_hold", k), count, v.fin);
  endtask

  task automatic set_vec(input int k, input logic [7:0] s, input logic [7:0] e, input logic [1:0] m,
                         input logic [3:0] r, input logic [7:0] fin, input int off, input int len);
    vecs[k].s   = s;
    vecs[k].e   = e;
    vecs[k].m   = m;
    vecs[k].r   = r;
    vecs[k].fin = fin;
    vecs[k].off = off;
    vecs[k].len = len;
    vecs[k].cyc = len + 2;
  endtask

  initial begin
    logic [7:0] hv;
    int         n;
    bit         seen;

    pool = '{10, 11, 12, 13, 14,
             3, 4, 5, 6, 5, 4, 3, 3, 4, 5, 6, 5, 4, 3,
             2, 1, 0, 255, 254,
             7, 7, 7,
             250, 251, 252, 253, 254, 255, 0, 1, 2,
             5, 5,
             0, 1, 2, 3, 0, 1, 2, 3,
             9, 8, 7, 6};
    set_vec(0, 8'd10,  8'd14,  2'b00, 4'd0, 8'd14,  0,  5);
    set_vec(1, 8'd3,   8'd6,   2'b10, 4'd1, 8'd3,   5,  14);
    set_vec(2, 8'd2,   8'd254, 2'b01, 4'd0, 8'd254, 19, 5);
    set_vec(3, 8'd7,   8'd7,   2'b00, 4'd2, 8'd7,   24, 3);
    set_vec(4, 8'd250, 8'd2,   2'b00, 4'd0, 8'd2,   27, 9);
    set_vec(5, 8'd5,   8'd5,   2'b10, 4'd1, 8'd5,   36, 2);
    set_vec(6, 8'd0,   8'd3,   2'b11, 4'd1, 8'd3,   38, 8);
    set_vec(7, 8'd9,   8'd6,   2'b01, 4'd0, 8'd6,   46, 4);

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_start = 8'd0;
    cmd_end   = 8'd0;
    cmd_mode  = 2'b00;
    cmd_reps  = 4'd0;
    abort     = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_load_ud", {cnt_load, cnt_u_d}, 2'b11);
    chk("rst_data", cnt_data, count);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 8; k++) run_cmd(vecs[k], k);

    // Reset asserted in the middle of a running sweep.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = 8'd0; cmd_end = 8'd100; cmd_mode = 2'b00; cmd_reps = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    hv = count;
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy_done", {busy, done}, 2'b00);
    chk("mid_rst_hold", {cnt_load, cnt_data}, {1'b1, hv});
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid_post_hold%0d", i), count, hv);
      chk($sformatf("mid_post_idle%0d", i), {done, busy, cmd_ready}, 3'b001);
    end

    // Abort at count 20 of a 0->100 up sweep.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = 8'd0; cmd_end = 8'd100; cmd_mode = 2'b00; cmd_reps = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (count != 8'd20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach20", count, 20);
    abort = 1'b1;
    #1;
    chk("abort_hold", {cnt_load, cnt_data}, {1'b1, 8'd20});
    @(negedge clk);
    abort = 1'b0;
    chk("abort_count", count, 20);
    chk("abort_idle", {done, busy, cmd_ready}, 3'b001);
    @(negedge clk);
    chk("abort_count2", count, 20);
    run_cmd(vecs[0], 8);

    // cmd_valid held through DONE must not be taken until the cycle after done.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = 8'd7; cmd_end = 8'd7; cmd_mode = 2'b00; cmd_reps = 4'd2;
    n = 0;
    seen = 1'b0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bb_done_seen", seen, 1);
    chk("bb_cycles", n, 5);
    chk("bb_done_ready", cmd_ready, 0);
    chk("bb_done_count", count, 7);
    @(negedge clk);
    chk("bb_idle", {done, busy, cmd_ready}, 3'b001);
    @(negedge clk);
    chk("bb_accepted", {busy, cmd_ready}, 2'b10);
    cmd_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bb2_done_seen", seen, 1);
    chk("bb2_cycles", n, 4);
    chk("bb2_count", count, 7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer that drives the load / up-down / data controls of the team's 8-bit up/down counter so it runs programmed sweeps.
- A command (start, end, mode, repeat count) is accepted over a valid/ready handshake.
- The block loads the counter, watches its count output, and reverses or reloads it at the end points.
- It pulses done after the last pass.
- It sits between a register/command interface and one counter instance. The counter has no enable, so this block holds it by reloading the current count.

Parameters:
WIDTH, 8, counter/data width
REP_W, 4, width of repeat field (passes = reps+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept command (IDLE only)
cmd_start  in  WIDTH  sweep start value
cmd_end  in  WIDTH  sweep end value
cmd_mode  in  2  00 up, 01 down, 10 triangle (start->end->start), 11 reserved (treated as up)
cmd_reps  in  REP_W  additional passes after the first
abort  in  1  synchronous abort of the running command
count  in  WIDTH  counter's current value
cnt_load  out  1  to counter load
cnt_u_d  out  1  to counter u_d (1 = up)
cnt_data  out  WIDTH  to counter data
busy  out  1  high in LOAD/RUN/DONE
done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset (rst low, async): state IDLE; internal regs start/end/mode/reps_left/dir/leg cleared to 0.
- Outputs during reset: cmd_ready=1, busy=0, done=0, cnt_load=1, cnt_data=count, cnt_u_d=1.
- cnt_load, cnt_data and cnt_u_d are combinational from state, registers and count. done is registered.
- IDLE:
  - Hold the counter: cnt_load=1, cnt_data=count. cmd_ready=1.
  - cmd_valid&cmd_ready captures all cmd fields; reps_left=cmd_reps; leg=0.
  - dir=1 for up/triangle, 0 for down. Next state LOAD.
- LOAD (1 cycle): cnt_load=1, cnt_data=start; next RUN. The count input equals start on the first RUN cycle.
- RUN: default cnt_load=0, cnt_u_d=dir. target = end when leg=0, start when leg=1. On count==target ("reach"):
  - Up/down mode, or triangle on leg 1: the pass is complete.
    - If reps_left!=0: cnt_load=1, cnt_data=start, reps_left--, leg=0, dir restored; stay RUN.
    - If reps_left==0: cnt_load=1, cnt_data=count (hold); next DONE.
  - Triangle on leg 0 with start!=end: dir flips and cnt_u_d drives the new dir this same cycle, so the next count is end-1 (down) or end+1. leg=1.
  - Triangle with start==end: reach on leg 0 counts as a complete pass (leg 1 skipped).
- Wrap-around: no range check.
  - Up mode with end<start wraps 255->0 modulo 2^WIDTH until end is reached; down mode is symmetric.
  - start==end in up/down mode completes each pass on its first RUN cycle.
- Timing: up pass with start<end reaches at RUN cycle (end-start)+1. Each reload costs 1 cycle at the value start.
- DONE (1 cycle): hold the counter; done=1; busy=1; cmd_ready=0; next IDLE.
- abort=1 in LOAD/RUN: the same cycle holds (cnt_load=1, cnt_data=count); next IDLE; no done. abort is ignored in IDLE/DONE.
- A command cannot be accepted in the DONE cycle. Earliest back-to-back accept is the cycle after done.
- Async reset mid-command: immediate return to IDLE; no done; the captured command is discarded.

Test Plan:
- Reset asserted mid-RUN -> immediately cmd_ready=1, busy=0, done=0, cnt_load=1; after release the counter holds its value.
- Up cmd start=10 end=14 reps=0 -> count sequence 10,11,12,13,14 then held at 14; done pulses once the cycle after count first shows 14; 7 cycles accept->done.
- Triangle start=3 end=6 reps=1 -> count 3,4,5,6,5,4,3,3(reload),4,5,6,5,4,3 then hold at 3; single done pulse.
- Down start=2 end=254 reps=0 -> count 2,1,0,255,254 (wrap) then hold at 254; done.
- abort asserted when count=20 during up 0->100 -> count holds at 20, no done, cmd_ready=1 the next cycle; a new command is accepted normally.
- start=end=7 up reps=2 -> three 1-cycle passes at 7 (count stays 7 throughout), done pulses; cmd_valid held high during DONE is not accepted until the following cycle.
